// File: rtl/conv_encoder.sv
// Rate-1/r convolutional encoder: encodes a message MSB-first, streams symbols,
// assembles the codeword and exports the expected-parity trellis table.
module conv_encoder #(
  parameter int r      = 2,
  parameter int K      = 3,
  parameter int lenout = 5,
  parameter int lenin  = 10,
  parameter logic [K-1:0] G0 = 3'b111,
  parameter logic [K-1:0] G1 = 3'b101
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [lenout-1:0]             msgin,
  output logic                          busy,
  output logic [r-1:0]                  sym_out,
  output logic                          sym_valid,
  output logic [lenin-1:0]              codeout,
  output logic                          finish,
  output logic [(1<<(K-1))*2*r-1:0]     states
);

  localparam int NS = 1 << (K - 1);
  localparam int TW = NS * 2 * r;
  localparam int CW = (lenout > 1) ? $clog2(lenout) : 1;
  localparam logic [CW-1:0] LAST = CW'(lenout - 1);

  // Table field (s<<1)|b holds the symbol emitted from state s on input bit b.
  function automatic logic [TW-1:0] build_table();
    logic [TW-1:0] t;
    logic [K-1:0]  w;
    t = '0;
    for (int s = 0; s < NS; s++) begin
      for (int b = 0; b < 2; b++) begin
        w = {b[0], s[K-2:0]};
        t[((s << 1) | b) * r +: r] = {^(w & G0), ^(w & G1)};
      end
    end
    return t;
  endfunction

  localparam logic [TW-1:0] C_TABLE = build_table();

  typedef enum logic [1:0] {IDLE, ENC, DONE} state_t;

  state_t            r_state, w_next;
  logic [lenout-1:0] r_msg;
  logic [K-2:0]      r_s;
  logic [CW-1:0]     r_cnt;
  logic [r-1:0]      r_sym;
  logic              r_sym_valid;
  logic [lenin-1:0]  r_code;
  logic              r_finish;
  logic              r_busy;
  logic [TW-1:0]     r_states;
  logic [K-1:0]      w_win;
  logic [r-1:0]      w_sym;

  assign w_win = {r_msg[lenout-1], r_s};
  assign w_sym = {^(w_win & G0), ^(w_win & G1)};

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start) w_next = ENC;
      ENC:     if (r_cnt == LAST) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_msg       <= '0;
      r_s         <= '0;
      r_cnt       <= '0;
      r_sym       <= '0;
      r_sym_valid <= 1'b0;
      r_code      <= '0;
      r_finish    <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_sym_valid <= 1'b0;
      r_finish    <= 1'b0;
      case (r_state)
        IDLE: if (start) begin
          r_msg  <= msgin;
          r_s    <= '0;
          r_cnt  <= '0;
          r_code <= '0;
          r_busy <= 1'b1;
        end
        ENC: begin
          r_sym       <= w_sym;
          r_sym_valid <= 1'b1;
          r_code[lenin-1-r*int'(r_cnt) -: r] <= w_sym;
          r_s         <= w_win[K-1:1];
          r_cnt       <= r_cnt + 1'b1;
          r_msg       <= {r_msg[lenout-2:0], 1'b0};
        end
        DONE: begin
          r_finish <= 1'b1;
          r_busy   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // Constant table, registered so it is valid from the first edge on.
  always_ff @(posedge clk) r_states <= C_TABLE;

  assign busy      = r_busy;
  assign sym_out   = r_sym;
  assign sym_valid = r_sym_valid;
  assign codeout   = r_code;
  assign finish    = r_finish;
  assign states    = r_states;

endmodule

// File: doc/conv_encoder.md
Name: conv_encoder

Overview:
- Rate-1/r convolutional encoder that sits directly upstream of the Viterbi decoder.
- Takes a lenout-bit message, encodes it MSB-first, and assembles the lenin-bit codeword. The first symbol lands at the codeword MSBs.
- Exports the expected-parity table (trellis) the decoder consumes as its state input.
- Also streams each r-bit symbol with a valid strobe for channel and noise-injection stages.

Parameters:
r, 2, parity bits per message bit (generator count)
K, 3, constraint length (window size)
lenout, 5, message length in bits
lenin, 10, codeword length; must equal r*lenout
G0, 3'b111, generator for parity bit p0 (MSB of each symbol)
G1, 3'b101, generator for parity bit p1 (LSB of each symbol)

Ports:
clk  input  1  clock; all logic on rising edge
rst  input  1  synchronous, active-high reset
start  input  1  one-cycle request; msgin sampled when accepted
msgin  input  lenout  message; msgin[lenout-1] is encoded first
busy  output  1  high while encoding
sym_out  output  r  current encoded symbol {p0,p1}
sym_valid  output  1  high for each cycle sym_out is new
codeout  output  lenin  assembled codeword; held until next accepted start
finish  output  1  one-cycle pulse when codeout is complete
states  output  (1<<(K-1))*2*r  parity table; field index idx=(s<<1)|b at bits [idx*r +: r]

Behaviour:
- Reset (rst=1 at an edge):
  - busy=0, sym_out=0, sym_valid=0, codeout=0, finish=0.
  - FSM goes to IDLE; shift state, bit counter and message register clear.
  - The states table is driven to its constant value.
- Reset mid-encode aborts the encode with no finish pulse. The next start begins from encoder state 0.
- Encoder state s (K-1 bits) = {u[t-1],u[t-2]}.
  - Window w = {u[t], s}.
  - p0 = XOR-reduce(w & G0); p1 = XOR-reduce(w & G1).
  - Next s = w[K-1:1].
- The states table follows the same equations with u[t]=b for every s and b.
  - With the default generators the table is 16'h963C.
  - The table is constant and is registered so it is stable from the first edge after reset.
- FSM states: IDLE, ENC, DONE.
- IDLE:
  - start=1 latches msgin, clears s to 0 and the bit counter to 0, and sets busy=1. Next state is ENC.
  - start=0: stay in IDLE.
- ENC: one message bit per cycle, MSB first. Each edge does the following:
  - Computes the symbol.
  - Drives sym_out with sym_valid=1.
  - Writes the symbol into codeout at bits [lenin-1-r*n -: r], where n is the bit counter.
  - Updates s and increments n.
- codeout is cleared at the start-accept edge, not incrementally visible as final. Downstream samples codeout only on finish.
- After the edge that processes bit lenout-1, the next state is DONE.
- DONE (one cycle):
  - finish=1, busy=0, sym_valid=0.
  - codeout holds the full codeword.
  - Next state is IDLE.
- Latency: start accepted at edge E0. Symbols appear after edges E1..E5 (lenout edges), and finish is high after edge E6.
- start while busy (ENC) is ignored, with no effect on the current encode.
- start in DONE is ignored. start is accepted in IDLE, so back-to-back encodes are spaced lenout+2 cycles.
- codeout and states widths are fixed by the parameters. No tail flush: the trellis is not terminated to 0, which matches the decoder's lenin=r*lenout.
- sym_out holds its last value when sym_valid=0.

Test Plan:
- Reset then idle: rst=1 for 2 cycles -> busy=0, finish=0, codeout=0, sym_valid=0, states=16'h963C.
- msgin=5'b10110, start pulse -> sym_out sequence 11,10,00,01,01 on 5 consecutive sym_valid cycles; finish pulse with codeout=10'h385; busy low same cycle.
- msgin=5'b11111 -> symbols 11,01,10,10,10; codeout=10'h36A. Then msgin=5'b00000 -> codeout=10'h000. This checks that s clears to 0 between encodes.
- start re-asserted during ENC with different msgin -> ignored; codeout=10'h385 for the original 10110 and exactly one finish pulse.
- rst=1 at the third ENC cycle -> all outputs zero next cycle with no finish. A fresh start with 10110 -> 10'h385.
- Loopback: feed codeout and states into the viterbi decoder for the three messages above -> decoder finish with codeout equal to the original msgin.
